program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 177 +++++++++++++++++
 tb/tb_program_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: receives a length-prefixed, checksummed image
// and writes it into CPU memory over the shared bus while holding the CPU halted.
module program_loader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_btn,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              mar_load,
  output logic              mem_st,
  output logic              hlt,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Wide enough to hold MEM_DEPTH and any DATA_W length byte without overflow.
  localparam int unsigned CNT_W = (DATA_W > ADDR_W) ? DATA_W + 1 : ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_MAR,
    S_STORE,
    S_SUM,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   len_q,   len_d;
  logic [DATA_W-1:0]   sum_q,   sum_d;
  logic [DATA_W-1:0]   byte_q,  byte_d;

  logic                xfer;
  logic                len_ok;
  logic                last_byte;
  logic [DATA_W-1:0]   sum_chk;

  assign xfer      = in_valid && !abort;
  assign len_ok    = (in_data != '0) && (CNT_W'(in_data) <= CNT_W'(MEM_DEPTH));
  assign last_byte = (CNT_W'(addr_q) + CNT_W'(1)) == CNT_W'(len_q);
  assign sum_chk   = sum_q + in_data;

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    sum_d     = sum_q;
    byte_d    = byte_q;
    in_ready  = 1'b0;
    bus_out   = '0;
    bus_drive = 1'b0;
    mar_load  = 1'b0;
    mem_st    = 1'b0;
    hlt       = 1'b0;
    cpu_rst   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN;
      end

      S_LEN: begin
        in_ready = 1'b1;
        hlt      = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_d = S_ERR;
        end else if (xfer) begin
          if (len_ok) begin
            len_d   = in_data;
            addr_d  = '0;
            sum_d   = in_data;
            state_d = S_DATA;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_DATA: begin
        in_ready = 1'b1;
        hlt      = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_d = S_ERR;
        end else if (xfer) begin
          byte_d  = in_data;
          sum_d   = sum_chk;
          state_d = S_MAR;
        end
      end

      S_MAR: begin
        hlt       = 1'b1;
        busy      = 1'b1;
        bus_drive = 1'b1;
        mar_load  = 1'b1;
        bus_out   = DATA_W'(addr_q);
        state_d   = abort ? S_ERR : S_STORE;
      end

      S_STORE: begin
        hlt       = 1'b1;
        busy      = 1'b1;
        bus_drive = 1'b1;
        mem_st    = 1'b1;
        bus_out   = byte_q;
        if (abort) begin
          state_d = S_ERR;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = last_byte ? S_SUM : S_DATA;
        end
      end

      S_SUM: begin
        in_ready = 1'b1;
        hlt      = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_d = S_ERR;
        end else if (xfer) begin
          state_d = (sum_chk == '0) ? S_DONE : S_ERR;
        end
      end

      S_DONE: begin
        hlt     = 1'b1;
        busy    = 1'b1;
        done    = 1'b1;
        cpu_rst = 1'b1;
        state_d = S_IDLE;
      end

      S_ERR: begin
        hlt   = 1'b1;
        error = 1'b1;
        if (start) state_d = S_LEN;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader: one row per clock cycle,
// outputs are Moore-style so each row's expectation is the current state's pattern.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_btn;
  logic       start, abort, in_valid;
  logic [7:0] in_data;
  logic       in_ready, bus_drive, mar_load, mem_st, hlt, cpu_rst, busy, done, error;
  logic [7:0] bus_out;

  program_loader #(
    .DATA_W   (8),
    .MEM_DEPTH(16),
    .ADDR_W   (4)
  ) dut (
    .clk      (clk),
    .rst_btn  (rst_btn),
    .start    (start),
    .abort    (abort),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bus_out  (bus_out),
    .bus_drive(bus_drive),
    .mar_load (mar_load),
    .mem_st   (mem_st),
    .hlt      (hlt),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Flag order: in_ready bus_drive mar_load mem_st hlt cpu_rst busy done error
  logic [8:0] act_flags;
  assign act_flags = {in_ready, bus_drive, mar_load, mem_st, hlt, cpu_rst, busy, done, error};

  localparam logic [8:0] P_IDLE  = 9'h000;
  localparam logic [8:0] P_LEN   = 9'h114;
  localparam logic [8:0] P_DATA  = 9'h114;
  localparam logic [8:0] P_MAR   = 9'h0D4;
  localparam logic [8:0] P_STORE = 9'h0B4;
  localparam logic [8:0] P_SUM   = 9'h114;
  localparam logic [8:0] P_DONE  = 9'h01E;
  localparam logic [8:0] P_ERR   = 9'h011;

  typedef struct {
    logic       st;
    logic       ab;
    logic       vld;
    logic [7:0] dat;
    logic [8:0] exp_flags;
    logic [7:0] exp_bus;
  } row_t;

  row_t vec[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic r(input logic st, input logic ab, input logic vld, input logic [7:0] dat,
                   input logic [8:0] fl, input logic [7:0] bus);
    row_t x;
    x.st = st; x.ab = ab; x.vld = vld; x.dat = dat; x.exp_flags = fl; x.exp_bus = bus;
    vec.push_back(x);
  endtask

  // Drive one row just after a rising edge, compare on the falling edge.
  task automatic apply(input row_t x, input int idx);
    start    = x.st;
    abort    = x.ab;
    in_valid = x.vld;
    in_data  = x.dat;
    @(negedge clk);
    check("flags", idx, 32'(act_flags), 32'(x.exp_flags));
    check("bus", idx, 32'(bus_out), 32'(x.exp_bus));
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    for (int i = 0; i < vec.size(); i++) apply(vec[i], i);
    vec.delete();
  endtask

  task automatic push_happy();
    r(0, 0, 0, 8'h00, P_IDLE,  8'h00);
    r(1, 0, 0, 8'h00, P_IDLE,  8'h00);
    r(0, 0, 1, 8'h03, P_LEN,   8'h00);
    r(0, 0, 1, 8'h1A, P_DATA,  8'h00);
    r(0, 0, 0, 8'h00, P_MAR,   8'h00);
    r(0, 0, 0, 8'h00, P_STORE, 8'h1A);
    r(0, 0, 1, 8'h2B, P_DATA,  8'h00);
    r(0, 0, 0, 8'h00, P_MAR,   8'h01);
    r(0, 0, 0, 8'h00, P_STORE, 8'h2B);
    r(0, 0, 1, 8'h3C, P_DATA,  8'h00);
    r(0, 0, 0, 8'h00, P_MAR,   8'h02);
    r(0, 0, 0, 8'h00, P_STORE, 8'h3C);
    r(0, 0, 1, 8'h7C, P_SUM,   8'h00);
    r(0, 0, 0, 8'h00, P_DONE,  8'h00);
    r(0, 0, 0, 8'h00, P_IDLE,  8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_btn = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    check("reset_flags", -1, 32'(act_flags), 32'(P_IDLE));
    check("reset_bus", -1, 32'(bus_out), 32'h0);
    @(negedge clk);
    rst_btn = 1'b1;
    @(posedge clk); #1;

    push_happy();
    // abort and stray in_valid in IDLE do nothing
    r(0, 1, 1, 8'h55, P_IDLE, 8'h00);
    r(0, 0, 0, 8'h00, P_IDLE, 8'h00);

    // length bounds: N=00 and N=11 rejected, abort ignored in ERR
    r(1, 0, 0, 8'h00, P_IDLE, 8'h00);
    r(0, 0, 1, 8'h00, P_LEN,  8'h00);
    r(0, 0, 1, 8'h05, P_ERR,  8'h00);
    r(0, 1, 0, 8'h00, P_ERR,  8'h00);
    r(1, 0, 0, 8'h00, P_ERR,  8'h00);
    r(0, 0, 1, 8'h11, P_LEN,  8'h00);
    r(0, 0, 0, 8'h00, P_ERR,  8'h00);

    // bad checksum: three stores then ERR
    r(1, 0, 0, 8'h00, P_ERR,   8'h00);
    r(0, 0, 1, 8'h03, P_LEN,   8'h00);
    r(0, 0, 1, 8'h1A, P_DATA,  8'h00);
    r(0, 0, 0, 8'h00, P_MAR,   8'h00);
    r(0, 0, 0, 8'h00, P_STORE, 8'h1A);
    r(0, 0, 1, 8'h2B, P_DATA,  8'h00);
    r(0, 0, 0, 8'h00, P_MAR,   8'h01);
    r(0, 0, 0, 8'h00, P_STORE, 8'h2B);
    r(0, 0, 1, 8'h3C, P_DATA,  8'h00);
    r(0, 0, 0, 8'h00, P_MAR,   8'h02);
    r(0, 0, 0, 8'h00, P_STORE, 8'h3C);
    r(0, 0, 1, 8'h00, P_SUM,   8'h00);
    r(0, 0, 0, 8'h00, P_ERR,   8'h00);
    r(0, 0, 0, 8'h00, P_ERR,   8'h00);

    // abort coincident with 2nd data transfer: no MAR/STORE for it
    r(1, 0, 0, 8'h00, P_ERR,   8'h00);
    r(0, 0, 1, 8'h03, P_LEN,   8'h00);
    r(0, 0, 1, 8'h1A, P_DATA,  8'h00);
    r(0, 0, 0, 8'h00, P_MAR,   8'h00);
    r(0, 0, 0, 8'h00, P_STORE, 8'h1A);
    r(0, 1, 1, 8'h2B, P_DATA,  8'h00);
    r(0, 0, 0, 8'h00, P_ERR,   8'h00);

    // recovery with maximum length N=16, bytes 01..10, checksum 68
    r(1, 0, 0, 8'h00, P_ERR, 8'h00);
    r(0, 0, 1, 8'h10, P_LEN, 8'h00);
    for (int i = 0; i < 16; i++) begin
      r(0, 0, 1, 8'(i + 1), P_DATA,  8'h00);
      r(0, 0, 0, 8'h00,     P_MAR,   8'(i));
      r(0, 0, 0, 8'h00,     P_STORE, 8'(i + 1));
    end
    r(0, 0, 1, 8'h68, P_SUM,  8'h00);
    r(0, 0, 0, 8'h00, P_DONE, 8'h00);
    r(0, 0, 0, 8'h00, P_IDLE, 8'h00);

    // backpressure: in_valid held through MAR/STORE, a stall, start ignored while busy
    r(1, 0, 0, 8'h00, P_IDLE,  8'h00);
    r(0, 0, 1, 8'h02, P_LEN,   8'h00);
    r(0, 0, 0, 8'h11, P_DATA,  8'h00);
    r(1, 0, 1, 8'h11, P_DATA,  8'h00);
    r(0, 0, 1, 8'h55, P_MAR,   8'h00);
    r(0, 0, 1, 8'h55, P_STORE, 8'h11);
    r(0, 0, 1, 8'h22, P_DATA,  8'h00);
    r(0, 0, 1, 8'h66, P_MAR,   8'h01);
    r(1, 0, 1, 8'h66, P_STORE, 8'h22);
    r(0, 0, 1, 8'hCB, P_SUM,   8'h00);
    r(0, 0, 1, 8'hCB, P_DONE,  8'h00);
    r(0, 0, 0, 8'h00, P_IDLE,  8'h00);
    run_table();

    // asynchronous reset in the middle of a STORE cycle
    r(1, 0, 0, 8'h00, P_IDLE, 8'h00);
    r(0, 0, 1, 8'h03, P_LEN,  8'h00);
    r(0, 0, 1, 8'h1A, P_DATA, 8'h00);
    r(0, 0, 0, 8'h00, P_MAR,  8'h00);
    run_table();
    check("pre_rst_flags", -2, 32'(act_flags), 32'(P_STORE));
    check("pre_rst_bus", -2, 32'(bus_out), 32'h1A);
    rst_btn = 1'b0;
    #1;
    check("async_rst_flags", -2, 32'(act_flags), 32'(P_IDLE));
    check("async_rst_bus", -2, 32'(bus_out), 32'h0);
    @(posedge clk); #1;
    check("held_rst_flags", -2, 32'(act_flags), 32'(P_IDLE));
    @(negedge clk);
    rst_btn = 1'b1;
    @(posedge clk); #1;
    push_happy();
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
